// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timer slice.
// Contents:
//   state_t        - FSM state encoding (IDLE=0, RUN=1, PAUSE=2, HALT=3)
//   MOD_DEC        - modulus of the decimal digits (c1, c10, s1, m1)
//   MOD_HEX6       - modulus of the tens-of-seconds/minutes digits (s10, m10)
//   OFF_*          - bit offsets of each BCD digit on the 24-bit time bus
//   TIME_TERMINAL  - highest representable time, 59:59.99
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int MOD_DEC  = 10;
  localparam int MOD_HEX6 = 6;

  // Time bus packing is {m10, m1, s10, s1, c10, c1}, one nibble each
  localparam int OFF_C1  = 0;
  localparam int OFF_C10 = 4;
  localparam int OFF_S1  = 8;
  localparam int OFF_S10 = 12;
  localparam int OFF_M1  = 16;
  localparam int OFF_M10 = 20;

  localparam logic [23:0] TIME_TERMINAL = 24'h595999;

endpackage

// File: rtl/stopwatch_timer_bcd_digit.sv
// One BCD digit counter with a configurable modulus.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset, zeroes the digit
//   clr    in   synchronous clear, zeroes the digit
//   inc    in   advance the digit by one this cycle
//   q      out  current digit value, always 0..MOD-1
//   carry  out  inc while the digit is at MOD-1; feeds the next digit's inc
module bcd_digit #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [3:0] LAST = 4'(MOD - 1);

  logic [3:0] r_q;

  // The digit rolls to zero after MOD-1, so it can never hold a non-BCD
  // value; reset and clear both beat an increment arriving the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= 4'd0;
    end else if (inc) begin
      r_q <= (r_q == LAST) ? 4'd0 : r_q + 4'd1;
    end
  end

  // Combinational carry so a whole chain of digits rolls over in one cycle
  assign carry = inc && (r_q == LAST);
  assign q     = r_q;

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch time-keeping stage: counts centisecond ticks into MM:SS.CC as six
// BCD digits, with a start/stop/clear FSM and a lap-hold display register.
// Parameters:
//   SATURATE    1 = stop at 59:59.99 and flag overflow, 0 = wrap to zero
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   tick        in   1-cycle pulse every 10 ms
//   start_stop  in   1-cycle pulse, toggles run/pause
//   clear       in   1-cycle pulse, zero time, go idle, drop lap hold
//   lap         in   1-cycle pulse, freeze/unfreeze the display
//   time_live   out  {m10,m1,s10,s1,c10,c1} live count
//   time_disp   out  lap hold value while lap_active, else time_live
//   running     out  high in RUN
//   lap_active  out  high while the display is frozen
//   overflow    out  sticky terminal/wrap flag
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] time_live,
  output logic [23:0] time_disp,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  state_t      r_state;
  logic        r_running;
  logic        r_lapActive;
  logic        r_overflow;
  logic [23:0] r_hold;

  logic [23:0] w_timeLive;
  logic        w_tickRun;
  logic        w_atTerminal;
  logic        w_satBlock;
  logic        w_incEn;
  logic [3:0]  w_c1, w_c10, w_s1, w_s10, w_m1, w_m10;
  logic        w_cyC1, w_cyC10, w_cyS1, w_cyS10, w_cyM1, w_cyM10;

  // A tick only counts while already in RUN, which is what makes a
  // start_stop+tick from IDLE/PAUSE skip that tick and one from RUN count it.
  assign w_tickRun    = tick && (r_state == ST_RUN);
  assign w_atTerminal = (w_timeLive == TIME_TERMINAL);
  // In saturating mode the tick that arrives on 59:59.99 is swallowed and
  // sends the FSM to HALT instead of rolling the digits over.
  assign w_satBlock   = SATURATE && w_tickRun && w_atTerminal;
  assign w_incEn      = w_tickRun && !w_satBlock;

  // Digit chain, least significant first; carries ripple combinationally.
  bcd_digit #(.MOD(MOD_DEC))  u_c1  (.clk(clk), .rst(rst), .clr(clear), .inc(w_incEn), .q(w_c1),  .carry(w_cyC1));
  bcd_digit #(.MOD(MOD_DEC))  u_c10 (.clk(clk), .rst(rst), .clr(clear), .inc(w_cyC1),  .q(w_c10), .carry(w_cyC10));
  bcd_digit #(.MOD(MOD_DEC))  u_s1  (.clk(clk), .rst(rst), .clr(clear), .inc(w_cyC10), .q(w_s1),  .carry(w_cyS1));
  bcd_digit #(.MOD(MOD_HEX6)) u_s10 (.clk(clk), .rst(rst), .clr(clear), .inc(w_cyS1),  .q(w_s10), .carry(w_cyS10));
  bcd_digit #(.MOD(MOD_DEC))  u_m1  (.clk(clk), .rst(rst), .clr(clear), .inc(w_cyS10), .q(w_m1),  .carry(w_cyM1));
  bcd_digit #(.MOD(MOD_HEX6)) u_m10 (.clk(clk), .rst(rst), .clr(clear), .inc(w_cyM1),  .q(w_m10), .carry(w_cyM10));

  assign w_timeLive[OFF_C1  +: 4] = w_c1;
  assign w_timeLive[OFF_C10 +: 4] = w_c10;
  assign w_timeLive[OFF_S1  +: 4] = w_s1;
  assign w_timeLive[OFF_S10 +: 4] = w_s10;
  assign w_timeLive[OFF_M1  +: 4] = w_m1;
  assign w_timeLive[OFF_M10 +: 4] = w_m10;

  // Control FSM together with the lap hold and the sticky overflow flag.
  // running is registered alongside the state so it never glitches.
  // The top digit only carries out when the whole count wraps, which is
  // the non-saturating overflow event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_running   <= 1'b0;
      r_lapActive <= 1'b0;
      r_overflow  <= 1'b0;
      r_hold      <= 24'd0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_running   <= 1'b0;
      r_lapActive <= 1'b0;
      r_overflow  <= 1'b0;
      r_hold      <= 24'd0;
    end else begin
      if (w_satBlock || w_cyM10) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (start_stop) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_satBlock) begin
            r_state   <= ST_HALT;
            r_running <= 1'b0;
          end else if (start_stop) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_HALT: begin
          r_state   <= ST_HALT;
          r_running <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase

      // Lap always releases an active hold; it only captures while running.
      // The capture takes the current register value, i.e. before any
      // increment caused by a tick in the same cycle.
      if (lap) begin
        if (r_lapActive) begin
          r_lapActive <= 1'b0;
        end else if (r_state == ST_RUN) begin
          r_lapActive <= 1'b1;
          r_hold      <= w_timeLive;
        end
      end
    end
  end

  assign time_live  = w_timeLive;
  assign time_disp  = r_lapActive ? r_hold : w_timeLive;
  assign running    = r_running;
  assign lap_active = r_lapActive;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Testbench for stopwatch_timer. Two instances share the stimulus: one
// saturating, one wrapping. Expected values are queued after each stimulus
// cycle and a monitor compares them on the following falling edge.
module tb_stopwatch_timer;

  localparam int SIG_LIVE = 0;
  localparam int SIG_DISP = 1;
  localparam int SIG_RUN  = 2;
  localparam int SIG_LAP  = 3;
  localparam int SIG_OVF  = 4;

  typedef struct {
    string       name;
    int          sig;
    bit          wrapInst;
    logic [23:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic [23:0] liveS, dispS, liveW, dispW;
  logic        runS, lapS, ovfS, runW, lapW, ovfW;

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;

  stopwatch_timer #(.SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .time_live(liveS), .time_disp(dispS), .running(runS), .lap_active(lapS), .overflow(ovfS)
  );

  stopwatch_timer #(.SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .time_live(liveW), .time_disp(dispW), .running(runW), .lap_active(lapW), .overflow(ovfW)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  function automatic logic [23:0] pick(int sig, bit w);
    case (sig)
      SIG_LIVE: return w ? liveW : liveS;
      SIG_DISP: return w ? dispW : dispS;
      SIG_RUN:  return {23'd0, (w ? runW : runS)};
      SIG_LAP:  return {23'd0, (w ? lapW : lapS)};
      default:  return {23'd0, (w ? ovfW : ovfS)};
    endcase
  endfunction

  // Monitor: drains every pending expectation on the falling edge, away
  // from the edge that updates the registered outputs.
  always @(negedge clk) begin
    while (sbQ.size() > 0) begin
      exp_t        e;
      logic [23:0] act;
      e   = sbQ.pop_front();
      act = pick(e.sig, e.wrapInst);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h, want %h", e.name, act, e.exp);
      end
    end
  end

  // Queue one expected output value for the monitor
  task automatic checkOutput(input string name, input bit wrapInst, input int sig,
                             input logic [23:0] exp);
    exp_t e;
    e.name     = name;
    e.sig      = sig;
    e.wrapInst = wrapInst;
    e.exp      = exp;
    sbQ.push_back(e);
  endtask

  // Drive one cycle of pulses, then drop them just after the rising edge
  task automatic applyStimulus(input bit ss, input bit clr, input bit lp, input bit tk);
    @(negedge clk);
    start_stop = ss;
    clear      = clr;
    lap        = lp;
    tick       = tk;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    tick       = 1'b0;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Jump both instances' digits to a given time, far away from reset,
  // without spending hundreds of thousands of ticks getting there.
  task automatic preload(input logic [23:0] v);
    @(negedge clk);
    #1;
    force dut.u_c1.r_q      = v[3:0];
    force dut.u_c10.r_q     = v[7:4];
    force dut.u_s1.r_q      = v[11:8];
    force dut.u_s10.r_q     = v[15:12];
    force dut.u_m1.r_q      = v[19:16];
    force dut.u_m10.r_q     = v[23:20];
    force dutWrap.u_c1.r_q  = v[3:0];
    force dutWrap.u_c10.r_q = v[7:4];
    force dutWrap.u_s1.r_q  = v[11:8];
    force dutWrap.u_s10.r_q = v[15:12];
    force dutWrap.u_m1.r_q  = v[19:16];
    force dutWrap.u_m10.r_q = v[23:20];
    #1;
    release dut.u_c1.r_q;
    release dut.u_c10.r_q;
    release dut.u_s1.r_q;
    release dut.u_s10.r_q;
    release dut.u_m1.r_q;
    release dut.u_m10.r_q;
    release dutWrap.u_c1.r_q;
    release dutWrap.u_c10.r_q;
    release dutWrap.u_s1.r_q;
    release dutWrap.u_s10.r_q;
    release dutWrap.u_m1.r_q;
    release dutWrap.u_m10.r_q;
  endtask

  initial begin
    $display("[TB] stopwatch_timer bench starting");

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_live", 1'b0, SIG_LIVE, 24'h000000);
    checkOutput("rst_disp", 1'b0, SIG_DISP, 24'h000000);
    checkOutput("rst_run",  1'b0, SIG_RUN,  24'd0);
    checkOutput("rst_lap",  1'b0, SIG_LAP,  24'd0);
    checkOutput("rst_ovf",  1'b0, SIG_OVF,  24'd0);
    checkOutput("rst_liveW", 1'b1, SIG_LIVE, 24'h000000);

    // Start from IDLE, then 100 ticks is one second
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_run",  1'b0, SIG_RUN,  24'd1);
    checkOutput("start_live", 1'b0, SIG_LIVE, 24'h000000);
    runTicks(100);
    checkOutput("sec_live",  1'b0, SIG_LIVE, 24'h000100);
    checkOutput("sec_liveW", 1'b1, SIG_LIVE, 24'h000100);
    checkOutput("sec_run",   1'b0, SIG_RUN,  24'd1);
    checkOutput("sec_ovf",   1'b0, SIG_OVF,  24'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("clr_live", 1'b0, SIG_LIVE, 24'h000000);
    checkOutput("clr_run",  1'b0, SIG_RUN,  24'd0);

    // Pause with a coincident tick: the tick counts, then counting stops
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(5);
    checkOutput("c05_live", 1'b0, SIG_LIVE, 24'h000005);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("pause_live", 1'b0, SIG_LIVE, 24'h000006);
    checkOutput("pause_run",  1'b0, SIG_RUN,  24'd0);
    runTicks(10);
    checkOutput("paused_live", 1'b0, SIG_LIVE, 24'h000006);
    // Resume with a coincident tick: that tick is not counted
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("resume_live", 1'b0, SIG_LIVE, 24'h000006);
    checkOutput("resume_run",  1'b0, SIG_RUN,  24'd1);

    // Lap hold
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(250);
    checkOutput("lap_pre_live", 1'b0, SIG_LIVE, 24'h000250);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lap_on",   1'b0, SIG_LAP,  24'd1);
    checkOutput("lap_disp", 1'b0, SIG_DISP, 24'h000250);
    runTicks(30);
    checkOutput("lap_adv_live", 1'b0, SIG_LIVE, 24'h000280);
    checkOutput("lap_adv_disp", 1'b0, SIG_DISP, 24'h000250);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lap_off",      1'b0, SIG_LAP,  24'd0);
    checkOutput("lap_off_disp", 1'b0, SIG_DISP, 24'h000280);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("laptick_lap",  1'b0, SIG_LAP,  24'd1);
    checkOutput("laptick_disp", 1'b0, SIG_DISP, 24'h000280);
    checkOutput("laptick_live", 1'b0, SIG_LIVE, 24'h000281);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("clrlap_live", 1'b0, SIG_LIVE, 24'h000000);
    checkOutput("clrlap_disp", 1'b0, SIG_DISP, 24'h000000);
    checkOutput("clrlap_lap",  1'b0, SIG_LAP,  24'd0);
    checkOutput("clrlap_run",  1'b0, SIG_RUN,  24'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_lap_ign", 1'b0, SIG_LAP, 24'd0);

    // Full carry ripple from 09:59.99 in a single tick
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    preload(24'h095999);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("carry_live",  1'b0, SIG_LIVE, 24'h100000);
    checkOutput("carry_liveW", 1'b1, SIG_LIVE, 24'h100000);

    // Terminal count: reaching 59:59.99 does not halt, the next tick does
    preload(24'h595998);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("term_live", 1'b0, SIG_LIVE, 24'h595999);
    checkOutput("term_run",  1'b0, SIG_RUN,  24'd1);
    checkOutput("term_ovf",  1'b0, SIG_OVF,  24'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sat_live",  1'b0, SIG_LIVE, 24'h595999);
    checkOutput("sat_ovf",   1'b0, SIG_OVF,  24'd1);
    checkOutput("sat_run",   1'b0, SIG_RUN,  24'd0);
    checkOutput("wrap_live", 1'b1, SIG_LIVE, 24'h000000);
    checkOutput("wrap_ovf",  1'b1, SIG_OVF,  24'd1);
    checkOutput("wrap_run",  1'b1, SIG_RUN,  24'd1);
    // HALT ignores start_stop and tick; the wrapping copy counts then pauses
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("halt_live",  1'b0, SIG_LIVE, 24'h595999);
    checkOutput("halt_run",   1'b0, SIG_RUN,  24'd0);
    checkOutput("wrapP_live", 1'b1, SIG_LIVE, 24'h000001);
    checkOutput("wrapP_run",  1'b1, SIG_RUN,  24'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("hclr_live", 1'b0, SIG_LIVE, 24'h000000);
    checkOutput("hclr_run",  1'b0, SIG_RUN,  24'd0);
    checkOutput("hclr_ovf",  1'b0, SIG_OVF,  24'd0);
    checkOutput("hclr_ovfW", 1'b1, SIG_OVF,  24'd0);

    // Let the monitor drain the last batch
    @(negedge clk);
    #1;
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, want 0", sbQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
